// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor datapath.
package simple_processor_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int NUM_REGS_DEFAULT = 16;

    typedef enum logic [1:0] {
        FUNC_AND = 2'd0,
        FUNC_OR  = 2'd1,
        FUNC_XOR = 2'd2,
        FUNC_NOT = 2'd3
    } func_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one write port.
// Register 0 is hardwired to zero on both the read and the write side.
module reg_file
    import simple_processor_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEFAULT,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr1_i,
    input  logic [AW-1:0]         raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/writeback pipeline feeding an external ALU gate,
// with EX-stage forwarding and a register preload port.
module alu_issue
    import simple_processor_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEFAULT,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  func_t                 func_i,
    input  logic [AW-1:0]         rd_addr_i,
    input  logic [AW-1:0]         rs1_addr_i,
    input  logic [AW-1:0]         rs2_addr_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [AW-1:0]         ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output func_t                 func_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic                  wb_valid_o,
    output logic [AW-1:0]         wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [31:0]           retire_cnt_o
);

    logic                  ex_valid_q;
    func_t                 ex_func_q;
    logic [AW-1:0]         ex_rd_q;
    logic [DATA_WIDTH-1:0] ex_op1_q, ex_op1_d;
    logic [DATA_WIDTH-1:0] ex_op2_q, ex_op2_d;
    logic                  wb_valid_q;
    logic [AW-1:0]         wb_addr_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [31:0]           retire_cnt_q, retire_cnt_d;

    logic                  issue;
    logic                  ld_fire;
    logic                  fwd1, fwd2;
    logic                  rf_we;
    logic [AW-1:0]         rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [DATA_WIDTH-1:0] rf_rdata1, rf_rdata2;

    assign instr_ready_o = ~ld_valid_i;
    assign ld_ready_o    = ~ex_valid_q;
    assign issue         = instr_valid_i & instr_ready_o;
    assign ld_fire       = ld_valid_i & ld_ready_o;

    // Preload only fires with EX empty, so it never competes with writeback.
    assign rf_we    = ex_valid_q | ld_fire;
    assign rf_waddr = ex_valid_q ? ex_rd_q : ld_addr_i;
    assign rf_wdata = ex_valid_q ? alu_result_i : ld_data_i;

    reg_file #(
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk_i    (clk_i),
        .arst_i   (arst_i),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata),
        .raddr1_i (rs1_addr_i),
        .raddr2_i (rs2_addr_i),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    // The EX result is written at the same edge as this fetch, so forward it.
    assign fwd1 = ex_valid_q && (ex_rd_q != '0) && (rs1_addr_i == ex_rd_q);
    assign fwd2 = ex_valid_q && (ex_rd_q != '0) && (rs2_addr_i == ex_rd_q);

    always_comb begin
        ex_op1_d     = fwd1 ? alu_result_i : rf_rdata1;
        ex_op2_d     = fwd2 ? alu_result_i : rf_rdata2;
        retire_cnt_d = retire_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ex_valid_q   <= 1'b0;
            ex_func_q    <= FUNC_AND;
            ex_rd_q      <= '0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            ex_valid_q <= issue;
            wb_valid_q <= ex_valid_q;
            if (issue) begin
                ex_func_q <= func_i;
                ex_rd_q   <= rd_addr_i;
                ex_op1_q  <= ex_op1_d;
                ex_op2_q  <= ex_op2_d;
            end
            if (ex_valid_q) begin
                wb_addr_q    <= ex_rd_q;
                wb_data_q    <= alu_result_i;
                retire_cnt_q <= retire_cnt_d;
            end
        end
    end

    assign rs1_data_o   = ex_op1_q;
    assign rs2_data_o   = ex_op2_q;
    assign func_o       = ex_func_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_addr_o    = wb_addr_q;
    assign wb_data_o    = wb_data_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule
